// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions: data width, the canonical NOP and the
// fetch-entry layout used by the fetch queue and the IF/ID stage.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
// master = pipeline stages around the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import fetch_queue_pkg::*;

  logic                   fetch_valid_i;
  logic [XLEN-1:0]        pc_i;
  logic [XLEN-1:0]        instr_i;
  logic                   fetch_stall_o;
  logic                   flush_i;
  logic                   dec_ready_i;
  logic                   dec_valid_o;
  logic [XLEN-1:0]        dec_pc_o;
  logic [XLEN-1:0]        dec_instr_o;
  logic [$clog2(DEPTH):0] count_o;

  modport master (
    output fetch_valid_i, pc_i, instr_i, flush_i, dec_ready_i,
    input  fetch_stall_o, dec_valid_o, dec_pc_o, dec_instr_o, count_o
  );

  modport slave (
    input  fetch_valid_i, pc_i, instr_i, flush_i, dec_ready_i,
    output fetch_stall_o, dec_valid_o, dec_pc_o, dec_instr_o, count_o
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH x fetch-entry register array, synchronous write,
// asynchronous read. Contents are never cleared; validity lives in the
// controller's count.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of (PC, instruction) pairs between fetch and decode.
// Stalls the PC register when full, presents a NOP bubble when empty and
// discards everything on a redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          CLK,
  input  logic          nRESET,
  fetch_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // Full/empty come from the registered count only, so the stall never
  // depends combinationally on dec_ready_i.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.fetch_valid_i & ~full & ~bus.flush_i;
  assign pop   = ~empty & bus.dec_ready_i & ~bus.flush_i;

  assign wr_entry.pc    = bus.pc_i;
  assign wr_entry.instr = bus.instr_i;

  // Pointer and occupancy bookkeeping; flush returns to the reset state.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .CLK   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.fetch_stall_o = full;
  assign bus.dec_valid_o   = ~empty;
  assign bus.dec_pc_o      = empty ? '0        : head.pc;
  assign bus.dec_instr_o   = empty ? NOP_INSTR : head.instr;
  assign bus.count_o       = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH = 4): directed stimulus marks each
// pair it expects to be accepted; a negedge monitor keeps the expected queue
// and compares head, valid, count and stall every cycle.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic CLK;
  logic nRESET;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t pend;
  bit           pend_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[29:0], 2'b11} ^ 32'h1234_0000;
  endfunction

  // One cycle of stimulus; acc is the hand-determined acceptance of the pair.
  task automatic step(input bit fv, input logic [31:0] pc, input bit rdy,
                      input bit fl, input bit acc);
    @(posedge CLK);
    #1;
    bus.fetch_valid_i = fv;
    bus.pc_i          = pc;
    bus.instr_i       = instr_of(pc);
    bus.dec_ready_i   = rdy;
    bus.flush_i       = fl;
    pend.pc           = pc;
    pend.instr        = instr_of(pc);
    pend_acc          = acc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.dec_valid_o}, 32'd0);
    chk({tag, "_stall"}, {31'b0, bus.fetch_stall_o}, 32'd0);
    chk({tag, "_count"}, {29'b0, bus.count_o}, 32'd0);
    chk({tag, "_pc"}, bus.dec_pc_o, 32'h0);
    chk({tag, "_instr"}, bus.dec_instr_o, 32'h00000013);
  endtask

  // Monitor: compare against the expected queue, then advance it.
  always @(negedge CLK) begin
    if (nRESET) begin
      chk("count", {29'b0, bus.count_o}, exp_q.size());
      chk("stall", {31'b0, bus.fetch_stall_o}, {31'b0, exp_q.size() == DEPTH});
      chk("valid", {31'b0, bus.dec_valid_o}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() == 0) begin
        chk("bubble_pc", bus.dec_pc_o, 32'h0);
        chk("bubble_instr", bus.dec_instr_o, 32'h00000013);
      end else begin
        chk("head_pc", bus.dec_pc_o, exp_q[0].pc);
        chk("head_instr", bus.dec_instr_o, exp_q[0].instr);
      end
      if (bus.flush_i) begin
        exp_q.delete();
      end else begin
        if (bus.dec_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
        if (pend_acc) exp_q.push_back(pend);
      end
    end
  end

  initial begin
    bus.fetch_valid_i = 1'b0;
    bus.pc_i          = '0;
    bus.instr_i       = '0;
    bus.dec_ready_i   = 1'b0;
    bus.flush_i       = 1'b0;
    nRESET            = 1'b0;

    // Reset then idle
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    nRESET = 1'b1;
    step(0, 32'h0, 1, 0, 0);

    // Streaming: count holds at 1 across several pointer wraps
    for (int unsigned i = 0; i < 14; i++) step(1, 32'(i * 4), 1, 0, 1);
    repeat (2) step(0, 32'h0, 1, 0, 0);

    // Fill and stall
    for (int unsigned i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0, 1);
    step(1, 32'h10, 0, 0, 0);
    step(1, 32'h10, 1, 0, 0);
    step(1, 32'h10, 1, 0, 1);
    repeat (5) step(0, 32'h0, 1, 0, 0);

    // Flush with concurrent push and pop at count 3
    step(1, 32'h40, 0, 0, 1);
    step(1, 32'h44, 0, 0, 1);
    step(1, 32'h48, 0, 0, 1);
    step(1, 32'h4c, 1, 1, 0);
    step(1, 32'h100, 0, 0, 1);
    repeat (2) step(0, 32'h0, 1, 0, 0);

    // Simultaneous push/pop at count 2
    step(1, 32'h80, 0, 0, 1);
    step(1, 32'h84, 0, 0, 1);
    step(1, 32'h88, 1, 0, 1);
    repeat (3) step(0, 32'h0, 1, 0, 0);

    // Asynchronous reset mid-stream at count 3
    step(1, 32'hc0, 0, 0, 1);
    step(1, 32'hc4, 0, 0, 1);
    step(1, 32'hc8, 0, 0, 1);
    step(0, 32'h0, 0, 0, 0);
    #2;
    nRESET = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    @(posedge CLK);
    #1;
    nRESET = 1'b1;

    // Normal operation after reset
    step(1, 32'h200, 1, 0, 1);
    repeat (2) step(0, 32'h0, 1, 0, 0);
    @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
